// File: rtl/vga_mem_arbiter_if.sv
// CPU request/response and single-port memory bus of the video memory arbiter.
// The arbiter takes the slave side; the CPU and memory sit on the master side.
interface vga_mem_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [15:0]       cpu_wdata;
  logic              cpu_ack;
  logic [15:0]       cpu_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Time-slot arbiter sharing one synchronous 16-bit memory between VGA fetch and CPU.
// Define ARB_STATS_EN to add the saturating cpu_stall_count output.
module vga_mem_arbiter #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] FB_BASE  = ADDR_W'(16'h8000),
  parameter int                FB_WORDS = 19200
) (
  input  logic             clk_50MHz,
  input  logic             clear,
  input  logic             frame_start,
  input  logic             fetch_en,
  vga_mem_arbiter_if.slave bus,
  output logic [15:0]      data_from_mem_vga,
  output logic [2:0]       vga_counter,
  output logic             vga_valid
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]      cpu_stall_count
`endif
);

  typedef enum logic {IDLE, ACK} cpu_state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FB_WORDS - 1);

  cpu_state_t        state;
  cpu_state_t        state_next;
  logic [ADDR_W-1:0] vga_ptr;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       rdata_q;
  logic              fetch_pending;
  logic              rd_pending;
  logic              vga_issue;
  logic              cpu_grant;

  assign vga_issue = fetch_en && (vga_counter == 3'd0);

  // Slot 0 belongs to the VGA fetch; the CPU gets the port only from IDLE.
  always_comb begin
    state_next    = state;
    cpu_grant     = 1'b0;
    bus.mem_addr  = mem_addr_q;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (vga_issue) begin
      bus.mem_addr = FB_BASE + vga_ptr;
    end
    case (state)
      IDLE: begin
        if (bus.cpu_req && !vga_issue) begin
          cpu_grant     = 1'b1;
          bus.mem_addr  = bus.cpu_addr;
          bus.mem_we    = bus.cpu_we;
          bus.mem_wdata = bus.cpu_wdata;
          state_next    = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read data arrives during ACK, so it is passed through then and held afterwards.
  assign bus.cpu_ack   = (state == ACK);
  assign bus.cpu_rdata = (state == ACK && rd_pending) ? bus.mem_rdata : rdata_q;

  always_ff @(posedge clk_50MHz or posedge clear) begin
    if (clear) begin
      state             <= IDLE;
      vga_counter       <= 3'd0;
      vga_ptr           <= '0;
      fetch_pending     <= 1'b0;
      rd_pending        <= 1'b0;
      data_from_mem_vga <= 16'h0000;
      vga_valid         <= 1'b0;
      mem_addr_q        <= '0;
      rdata_q           <= 16'h0000;
    end else begin
      state         <= state_next;
      vga_counter   <= vga_counter + 3'd1;
      fetch_pending <= vga_issue;
      vga_valid     <= fetch_pending;
      mem_addr_q    <= bus.mem_addr;
      if (fetch_pending) begin
        data_from_mem_vga <= bus.mem_rdata;
      end
      if (cpu_grant) begin
        rd_pending <= !bus.cpu_we;
      end
      if (state == ACK && rd_pending) begin
        rdata_q <= bus.mem_rdata;
      end
      // A new frame restarts the framebuffer walk even if a capture lands now.
      if (frame_start) begin
        vga_ptr <= '0;
      end else if (fetch_pending) begin
        vga_ptr <= (vga_ptr == LAST_WORD) ? '0 : vga_ptr + ADDR_W'(1);
      end
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk_50MHz or posedge clear) begin
    if (clear) begin
      cpu_stall_count <= 16'h0000;
    end else if (frame_start) begin
      cpu_stall_count <= 16'h0000;
    end else if (state == IDLE && bus.cpu_req && !cpu_grant && cpu_stall_count != 16'hFFFF) begin
      cpu_stall_count <= cpu_stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scoreboard bench for vga_mem_arbiter: directed stimulus queues expected VGA words
// and CPU acks; a negedge monitor pops and compares whenever the DUT presents them.
module tb_vga_mem_arbiter;

  typedef struct {
    logic        rd;
    logic [15:0] data;
    logic [2:0]  slot;
  } cpu_exp_t;

  logic        clk = 1'b0;
  logic        clear;
  logic        frame_start;
  logic        fetch_en;
  logic [15:0] data_from_mem_vga;
  logic [2:0]  vga_counter;
  logic        vga_valid;
`ifdef ARB_STATS_EN
  logic [15:0] cpu_stall_count;
`endif

  logic [15:0] mem [0:65535];
  logic [15:0] vga_q [$];
  cpu_exp_t    cpu_q [$];
  cpu_exp_t    mon_cpu;
  logic [15:0] mon_vga;
  int          total = 0;
  int          bad = 0;

  logic [15:0] fetch_vals [6] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 16'h0001};
  logic [15:0] addr_tab   [6] = '{16'h8000, 16'h8001, 16'h8002, 16'h8003, 16'h8000, 16'h8001};
  logic [15:0] stall_vals [7] = '{16'h1234, 16'h0001, 16'h0002, 16'h0003, 16'h1234, 16'h0001, 16'h0002};

  vga_mem_arbiter_if #(.ADDR_W(16)) bus ();

  vga_mem_arbiter #(
    .ADDR_W  (16),
    .FB_BASE (16'h8000),
    .FB_WORDS(4)
  ) dut (
    .clk_50MHz        (clk),
    .clear            (clear),
    .frame_start      (frame_start),
    .fetch_en         (fetch_en),
    .bus              (bus.slave),
    .data_from_mem_vga(data_from_mem_vga),
    .vga_counter      (vga_counter),
    .vga_valid        (vga_valid)
`ifdef ARB_STATS_EN
    ,
    .cpu_stall_count  (cpu_stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory with one cycle of read latency.
  always @(posedge clk) begin
    bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  task automatic expect_cpu(input logic rd, input logic [15:0] data, input logic [2:0] slot);
    cpu_exp_t e;
    e.rd = rd;
    e.data = data;
    e.slot = slot;
    cpu_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_slot(input logic [2:0] s);
    int n = 0;
    do begin
      step();
      n++;
    end while (vga_counter != s && n < 16);
    check_output("wait_slot", 32'(vga_counter), 32'(s));
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_cpu_ack"}, 32'(bus.cpu_ack), 0);
    check_output({tag, "_cpu_rdata"}, 32'(bus.cpu_rdata), 0);
    check_output({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
    check_output({tag, "_mem_we"}, 32'(bus.mem_we), 0);
    check_output({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
    check_output({tag, "_vga_data"}, 32'(data_from_mem_vga), 0);
    check_output({tag, "_vga_counter"}, 32'(vga_counter), 0);
    check_output({tag, "_vga_valid"}, 32'(vga_valid), 0);
`ifdef ARB_STATS_EN
    check_output({tag, "_stall_count"}, 32'(cpu_stall_count), 0);
`endif
  endtask

  // Monitor: every presented VGA word or CPU ack must match the oldest expectation.
  always @(negedge clk) begin
    if (vga_valid === 1'b1) begin
      check_output("vga_valid_expected", 32'(vga_q.size() != 0), 1);
      if (vga_q.size() != 0) begin
        mon_vga = vga_q.pop_front();
        check_output("vga_data", 32'(data_from_mem_vga), 32'(mon_vga));
        check_output("vga_valid_slot", 32'(vga_counter), 2);
      end
    end
    if (bus.cpu_ack === 1'b1) begin
      check_output("cpu_ack_expected", 32'(cpu_q.size() != 0), 1);
      if (cpu_q.size() != 0) begin
        mon_cpu = cpu_q.pop_front();
        check_output("cpu_ack_slot", 32'(vga_counter), 32'(mon_cpu.slot));
        if (mon_cpu.rd) check_output("cpu_rdata", 32'(bus.cpu_rdata), 32'(mon_cpu.data));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear = 1'b1;
    frame_start = 1'b0;
    fetch_en = 1'b0;
    apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 4; i++) mem[16'h8000 + i] = 16'(i);
    mem[16'h0010] = 16'hA5A5;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");

    // Free-running slots and six fetches wrapping over a 4-word framebuffer
    @(posedge clk);
    #1;
    clear = 1'b0;
    fetch_en = 1'b1;
    for (int k = 0; k < 48; k++) begin
      if (k > 0) step();
      if (k % 8 == 0) vga_q.push_back(fetch_vals[k / 8]);
      @(negedge clk);
      check_output("slot_phase", 32'(vga_counter), 32'(k % 8));
      if (k % 8 == 0) begin
        check_output("fetch_addr", 32'(bus.mem_addr), 32'(addr_tab[k / 8]));
        check_output("fetch_we", 32'(bus.mem_we), 0);
      end
    end
    step();
    fetch_en = 1'b0;

    // CPU read blocked by the slot-0 fetch, granted in slot 1
    wait_slot(3'd0);
    fetch_en = 1'b1;
    apply_stimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
    vga_q.push_back(16'h0002);
    expect_cpu(1'b1, 16'hA5A5, 3'd2);
    @(negedge clk);
    check_output("blocked_fetch_addr", 32'(bus.mem_addr), 32'h8002);
    step();
    fetch_en = 1'b0;
    @(negedge clk);
    check_output("grant_addr", 32'(bus.mem_addr), 32'h0010);
    check_output("grant_we", 32'(bus.mem_we), 0);
    step();
    apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);

    // frame_start coinciding with a slot-1 capture
    wait_slot(3'd0);
    fetch_en = 1'b1;
    vga_q.push_back(16'h0003);
    @(negedge clk);
    check_output("fetch_addr_w3", 32'(bus.mem_addr), 32'h8003);
    step();
    fetch_en = 1'b0;
    wait_slot(3'd0);
    fetch_en = 1'b1;
    vga_q.push_back(16'h0000);
    @(negedge clk);
    check_output("fetch_addr_w0", 32'(bus.mem_addr), 32'h8000);
    step();
    fetch_en = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;

    // CPU write in slot 7 is seen by the following slot-0 fetch
    wait_slot(3'd7);
    apply_stimulus(1'b1, 1'b1, 16'h8000, 16'h1234);
    expect_cpu(1'b0, 16'h0000, 3'd0);
    @(negedge clk);
    check_output("wr_mem_we", 32'(bus.mem_we), 1);
    check_output("wr_mem_addr", 32'(bus.mem_addr), 32'h8000);
    check_output("wr_mem_wdata", 32'(bus.mem_wdata), 32'h1234);
    step();
    apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    fetch_en = 1'b1;
    vga_q.push_back(16'h1234);
    @(negedge clk);
    check_output("after_frame_start_addr", 32'(bus.mem_addr), 32'h8000);
    step();
    fetch_en = 1'b0;
    @(negedge clk);
    check_output("idle_we", 32'(bus.mem_we), 0);
    check_output("idle_wdata", 32'(bus.mem_wdata), 0);
    check_output("idle_addr_hold", 32'(bus.mem_addr), 32'h8000);

    // Back-to-back reads: second grant in the cycle after the first ack
    wait_slot(3'd3);
    apply_stimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
    expect_cpu(1'b1, 16'hA5A5, 3'd4);
    expect_cpu(1'b1, 16'h0001, 3'd6);
    step();
    apply_stimulus(1'b1, 1'b0, 16'h8001, 16'h0000);
    step();
    @(negedge clk);
    check_output("b2b_grant_addr", 32'(bus.mem_addr), 32'h8001);
    step();
    apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    step();
    @(negedge clk);
    check_output("rdata_hold", 32'(bus.cpu_rdata), 32'h0001);

    // clear while the FSM sits in ACK drops the transaction
    wait_slot(3'd3);
    apply_stimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
    step();
    clear = 1'b1;
    apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    check_all_zero("mid_ack_clear");
    step();
    @(negedge clk);
    check_output("clear_held_ack", 32'(bus.cpu_ack), 0);
    step();
    clear = 1'b0;
    @(negedge clk);
    check_output("post_clear_ack", 32'(bus.cpu_ack), 0);
    check_output("post_clear_counter", 32'(vga_counter), 0);

    // Seven requests, each blocked for exactly one slot-0 cycle
    for (int i = 0; i < 7; i++) begin
      wait_slot(3'd0);
      fetch_en = 1'b1;
      apply_stimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
      vga_q.push_back(stall_vals[i]);
      expect_cpu(1'b1, 16'hA5A5, 3'd2);
      step();
      fetch_en = 1'b0;
      step();
      apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    end
`ifdef ARB_STATS_EN
    @(negedge clk);
    check_output("stall_count", 32'(cpu_stall_count), 7);
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    @(negedge clk);
    check_output("stall_count_cleared", 32'(cpu_stall_count), 0);
`endif

    repeat (16) step();
    check_output("vga_q_drained", 32'(vga_q.size()), 0);
    check_output("cpu_q_drained", 32'(cpu_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_mem_arbiter.md
Name: vga_mem_arbiter

Overview:
- Time-slot scheduler that shares one single-port, 16-bit synchronous video/data memory between the VGA pixel path and the CPU.
- Generates the 3-bit `vga_counter` slot phase that the VGA block consumes.
- Fetches one framebuffer word per 8-cycle slot frame into `data_from_mem_vga`.
- Grants the remaining memory cycles to the CPU through a req/ack handshake.

Parameters:
- ADDR_W, 16, memory word-address width.
- FB_BASE, 16'h8000, word address of framebuffer word 0.
- FB_WORDS, 19200, number of framebuffer words; VGA pointer wraps after FB_WORDS-1.

Ports:
- clk_50MHz  input  1  system clock; all state changes on its rising edge.
- clear  input  1  asynchronous, active-high reset.
- frame_start  input  1  one-cycle pulse at start of frame; resets VGA word pointer.
- fetch_en  input  1  high while the VGA path needs words (active/prefetch region).
- cpu_req  input  1  CPU access request; held with addr/we/wdata stable until cpu_ack.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  ADDR_W  CPU word address.
- cpu_wdata  input  16  CPU write data.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_rdata  output  16  read data, valid when cpu_ack=1 on a read.
- mem_addr  output  ADDR_W  memory address.
- mem_we  output  1  memory write enable.
- mem_wdata  output  16  memory write data.
- mem_rdata  input  16  memory read data; synchronous, 1-cycle latency.
- data_from_mem_vga  output  16  last fetched framebuffer word.
- vga_counter  output  3  slot phase 0..7.
- vga_valid  output  1  one-cycle pulse when data_from_mem_vga updates.

Behaviour:
- Reset values:
  - All outputs are 0.
  - VGA word pointer (vga_ptr) is 0.
  - CPU FSM is in IDLE.
  - An asserted clear mid-transaction drops that transaction; no ack is produced for it.
- vga_counter:
  - Free-running; increments every cycle and wraps 7->0.
- VGA fetch issue (slot 0 with fetch_en=1):
  - mem_addr = FB_BASE + vga_ptr, mem_we = 0.
  - The VGA fetch always owns slot 0 when fetch_en=1.
- VGA fetch capture (slot 1, only if the slot-0 fetch was issued):
  - data_from_mem_vga <= mem_rdata and vga_valid pulses; both visible in slot 2.
  - vga_ptr increments and wraps FB_WORDS-1 -> 0.
- frame_start:
  - Forces vga_ptr to 0 next cycle.
  - Wins over a same-cycle increment.
  - Does not disturb vga_counter.
- Idle memory port:
  - When neither requester drives the port: mem_we=0, mem_addr holds its previous value, mem_wdata=0.
- CPU FSM, two states:
  - IDLE: if cpu_req=1 and the current slot is not VGA-owned (slot != 0 or fetch_en=0), grant.
    - The port is driven combinationally from cpu_addr, cpu_we and cpu_wdata.
    - The FSM moves to ACK.
    - Otherwise it stays in IDLE (stall).
  - ACK: cpu_ack=1.
    - On a read, cpu_rdata <= mem_rdata registered from the issue cycle, presented in the same cycle as the ack.
    - The port is free to the VGA path; the FSM returns to IDLE.
- CPU throughput and latency:
  - Best case is one access per 2 cycles.
  - A request arriving in slot 0 with fetch_en=1 waits exactly 1 cycle.
  - Back-to-back requests: a new grant is possible in the cycle after ack.
- Write hazard: a CPU write to the word being fetched is ordered by slot. A write issued in slot 7 is seen by the slot-0 fetch.
- cpu_rdata holds its value between acks.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined:
  - Adds output cpu_stall_count[15:0], reset 0.
  - Increments each cycle the FSM is in IDLE with cpu_req=1 and no grant.
  - Saturates at 16'hFFFF.
  - Cleared by frame_start; the clear wins over an increment in the same cycle.
- When undefined: the port and counter do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset then release with fetch_en=1, memory preloaded word[8000h+n]=n -> vga_counter cycles 0..7; vga_valid pulses every 8 cycles; data_from_mem_vga = 0,1,2,3.
- Preset vga_ptr near the end (FB_WORDS=4 build) and fetch 6 words -> data sequence 0,1,2,3,0,1 from addresses 8000h..8003h,8000h,8001h.
- CPU read 0010h (contents A5A5h) requested in slot 0 with fetch_en=1 -> grant in slot 1; cpu_ack in slot 2 with cpu_rdata=A5A5h; VGA fetch unaffected.
- CPU write 8000h=1234h in slot 7, then observe the slot-0 fetch of word 0 -> data_from_mem_vga=1234h.
- frame_start asserted in the same cycle as a slot-1 capture -> vga_ptr=0 afterwards; the next fetch address is 8000h.
- Assert clear while the CPU FSM is in ACK -> cpu_ack=0 during and after reset; all outputs are 0; with ARB_STATS_EN, cpu_stall_count=0 and it counts 7 for a request held across 7 blocked cycles.
